// File: rtl/mbist_pkg.sv
// Shared types, encodings and march element tables for the memory BIST controller.
package mbist_pkg;

  localparam logic ALG_MATS_PLUS = 1'b0;
  localparam logic ALG_MARCH_CM  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // data = 0 selects the background, data = 1 its complement
  typedef struct packed {
    logic wr;
    logic data;
  } march_op_t;

  typedef struct packed {
    logic            down;
    logic [1:0]      n_ops;
    march_op_t [1:0] ops;   // ops[0] executes first
  } march_elem_t;

  localparam march_op_t R0 = 2'b00;
  localparam march_op_t R1 = 2'b01;
  localparam march_op_t W0 = 2'b10;
  localparam march_op_t W1 = 2'b11;

  function automatic march_elem_t mk_elem(input logic down, input logic [1:0] n_ops,
                                          input march_op_t op0, input march_op_t op1);
    march_elem_t e;
    e.down   = down;
    e.n_ops  = n_ops;
    e.ops[0] = op0;
    e.ops[1] = op1;
    return e;
  endfunction

  localparam int MATS_ELEMS     = 3;
  localparam int MARCH_CM_ELEMS = 6;
  localparam logic [2:0] MATS_LAST     = 3'(MATS_ELEMS - 1);
  localparam logic [2:0] MARCH_CM_LAST = 3'(MARCH_CM_ELEMS - 1);

  // Tables are listed last element first so index 0 is the first element.
  localparam march_elem_t [MATS_ELEMS-1:0] MATS_TBL = {
    mk_elem(1'b1, 2'd2, R1, W0),
    mk_elem(1'b0, 2'd2, R0, W1),
    mk_elem(1'b0, 2'd1, W0, W0)
  };

  localparam march_elem_t [MARCH_CM_ELEMS-1:0] MARCH_CM_TBL = {
    mk_elem(1'b0, 2'd1, R0, R0),
    mk_elem(1'b1, 2'd2, R1, W0),
    mk_elem(1'b1, 2'd2, R0, W1),
    mk_elem(1'b0, 2'd2, R1, W0),
    mk_elem(1'b0, 2'd2, R0, W1),
    mk_elem(1'b0, 2'd1, W0, W0)
  };

  function automatic march_elem_t get_elem(input logic alg, input logic [2:0] idx);
    march_elem_t e;
    if (alg == ALG_MATS_PLUS) begin
      e = (idx <= MATS_LAST) ? MATS_TBL[idx[1:0]] : MATS_TBL[0];
    end else begin
      e = (idx <= MARCH_CM_LAST) ? MARCH_CM_TBL[idx] : MARCH_CM_TBL[0];
    end
    return e;
  endfunction

  function automatic logic elem_down(input logic alg, input logic [2:0] idx);
    march_elem_t e;
    e = get_elem(alg, idx);
    return e.down;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter with load-to-0 / load-to-max and a direction-aware terminal flag.
module mbist_addr_gen #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          load_max_i,
  input  logic          en_i,
  input  logic          down_i,
  output logic [AW-1:0] addr_o,
  output logic          tc_o
);

  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_max_i ? '1 : '0;
    end else if (en_i) begin
      addr_d = down_i ? addr_q - AW'(1) : addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March-test BIST controller: sequences MATS+ / March C- over a single-port RAM and
// records the first miscompare plus a saturating miscompare count.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           alg_sel,
  input  logic           stop_on_fail,
  input  logic [DW-1:0]  bg_pat,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [DW-1:0]  mem_rdata,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic [AW-1:0]  fail_addr,
  output logic [DW-1:0]  fail_exp,
  output logic [DW-1:0]  fail_act,
  output logic [FCW-1:0] fail_cnt
);

  state_e           state_q, state_d;
  logic             alg_q, sof_q;
  logic [DW-1:0]    bg_q;
  logic [2:0]       elem_q, elem_d;
  logic             op_q, op_d;
  logic             rd_pend_q;
  logic [DW-1:0]    exp_q;
  logic [AW-1:0]    cmp_addr_q;
  logic             fail_q;
  logic [AW-1:0]    fail_addr_q;
  logic [DW-1:0]    fail_exp_q, fail_act_q;
  logic [FCW-1:0]   fail_cnt_q;

  march_elem_t      cur_elem;
  march_op_t        cur_op;
  logic             running, start_acc, op_last, elem_last, last_issue, mismatch;
  logic             ag_load, ag_load_max, ag_en, ag_tc;
  logic [AW-1:0]    ag_addr;
  logic [DW-1:0]    op_data;

  assign running    = (state_q == ST_RUN);
  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cur_elem   = get_elem(alg_q, elem_q);
  assign cur_op     = cur_elem.ops[op_q];
  assign op_last    = ({1'b0, op_q} == (cur_elem.n_ops - 2'd1));
  assign elem_last  = (elem_q == ((alg_q == ALG_MARCH_CM) ? MARCH_CM_LAST : MATS_LAST));
  assign last_issue = running && op_last && ag_tc && elem_last;
  assign op_data    = cur_op.data ? ~bg_q : bg_q;
  // Compares are only meaningful while the run is live; a read issued in the stop cycle is dropped.
  assign mismatch   = rd_pend_q && (running || (state_q == ST_DRAIN)) && (mem_rdata != exp_q);

  mbist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ag_load),
    .load_max_i (ag_load_max),
    .en_i       (ag_en),
    .down_i     (cur_elem.down),
    .addr_o     (ag_addr),
    .tc_o       (ag_tc)
  );

  // Op/address sequencing: finish all ops at an address, then step, then move to the next element.
  always_comb begin
    elem_d      = elem_q;
    op_d        = op_q;
    ag_load     = 1'b0;
    ag_load_max = 1'b0;
    ag_en       = 1'b0;
    if (start_acc) begin
      elem_d  = '0;
      op_d    = 1'b0;
      ag_load = 1'b1;
    end else if (running) begin
      if (!op_last) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (!ag_tc) begin
          ag_en = 1'b1;
        end else if (!elem_last) begin
          elem_d      = elem_q + 3'd1;
          ag_load     = 1'b1;
          ag_load_max = elem_down(alg_q, elem_q + 3'd1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_RUN;
      ST_RUN: begin
        if (mismatch && sof_q) begin
          state_d = ST_DONE;
        end else if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (start_acc) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_RUN: begin
        busy   = 1'b1;
        mem_we = cur_op.wr;
        mem_re = !cur_op.wr;
        if (cur_op.wr) mem_wdata = op_data;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_q      <= '0;
      op_q        <= 1'b0;
      alg_q       <= 1'b0;
      sof_q       <= 1'b0;
      bg_q        <= '0;
      rd_pend_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      elem_q     <= elem_d;
      op_q       <= op_d;
      rd_pend_q  <= mem_re;
      exp_q      <= op_data;
      cmp_addr_q <= ag_addr;
      if (start_acc) begin
        alg_q       <= alg_sel;
        sof_q       <= stop_on_fail;
        bg_q        <= bg_pat;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_act_q  <= '0;
        fail_cnt_q  <= '0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
        if (fail_cnt_q != {FCW{1'b1}}) fail_cnt_q <= fail_cnt_q + FCW'(1);
        if (!fail_q) begin
          fail_addr_q <= cmp_addr_q;
          fail_exp_q  <= exp_q;
          fail_act_q  <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = ag_addr;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: expected runs and ops are queued at start,
// monitors compare on each RAM op and on each rising done.
module tb_mbist_march_ctrl;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int N  = 16;

  typedef struct {
    int             cyc;
    logic           f;
    logic [AW-1:0]  a;
    logic [DW-1:0]  e;
    logic [DW-1:0]  x;
    int             cnt;
    int             ops;
  } run_exp_t;

  typedef struct {
    logic           we;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
  } op_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start2, alg_sel, stop_on_fail;
  logic [DW-1:0] bg_pat;
  logic [AW-1:0] mem_addr, fail_addr, mem_addr2, fail_addr2;
  logic [DW-1:0] mem_wdata, mem_rdata, fail_exp, fail_act;
  logic [DW-1:0] mem_wdata2, mem_rdata2, fail_exp2, fail_act2;
  logic          mem_we, mem_re, busy, done, fail;
  logic          mem_we2, mem_re2, busy2, done2, fail2;
  logic [7:0]    fail_cnt;
  logic [1:0]    fail_cnt2;

  mbist_march_ctrl #(.DW(DW), .AW(AW), .FCW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .alg_sel(alg_sel), .stop_on_fail(stop_on_fail),
    .bg_pat(bg_pat), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act), .fail_cnt(fail_cnt)
  );

  mbist_march_ctrl #(.DW(DW), .AW(AW), .FCW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .alg_sel(alg_sel), .stop_on_fail(stop_on_fail),
    .bg_pat(bg_pat), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
    .mem_re(mem_re2), .mem_rdata(mem_rdata2), .busy(busy2), .done(done2), .fail(fail2),
    .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_act(fail_act2), .fail_cnt(fail_cnt2)
  );

  // RAM models: the first can force bit 0 of address 5 high; the second always returns ~stored.
  logic [DW-1:0] ram  [N];
  logic [DW-1:0] ram2 [N];
  logic          fault_en = 1'b0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr] | ((fault_en && mem_addr == 4'd5) ? 4'h1 : 4'h0);
    if (mem_we2) ram2[mem_addr2] <= mem_wdata2;
    if (mem_re2) mem_rdata2 <= ~ram2[mem_addr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int op_count = 0;
  int we_after_done = 0;
  run_exp_t runq[$];
  run_exp_t runq2[$];
  op_exp_t  opq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Op monitor and done monitor for the main instance.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    op_exp_t  o;
    run_exp_t r;
    if (mem_we || mem_re) begin
      op_count++;
      if (done && mem_we) we_after_done++;
      if (opq.size() > 0) begin
        o = opq.pop_front();
        chk("op_we_addr_wdata", {mem_we, mem_addr, mem_we ? mem_wdata : 4'h0},
            {o.we, o.a, o.we ? o.d : 4'h0});
      end
    end
    if (done && !done_prev) begin
      chk("done_expected", runq.size() > 0, 1);
      if (runq.size() > 0) begin
        r = runq.pop_front();
        chk("done_cycle", cyc - t0, r.cyc);
        chk("fail", fail, r.f);
        chk("fail_addr", fail_addr, r.a);
        chk("fail_exp", fail_exp, r.e);
        chk("fail_act", fail_act, r.x);
        chk("fail_cnt", fail_cnt, r.cnt);
        chk("op_count", op_count, r.ops);
        chk("busy_low_at_done", busy, 0);
      end
    end
    done_prev = done;
  end

  logic done2_prev = 1'b0;
  always @(negedge clk) begin
    run_exp_t r;
    if (done2 && !done2_prev) begin
      chk("done2_expected", runq2.size() > 0, 1);
      if (runq2.size() > 0) begin
        r = runq2.pop_front();
        chk("done2_cycle", cyc - t0, r.cyc);
        chk("fail2", fail2, r.f);
        chk("fail_addr2", fail_addr2, r.a);
        chk("fail_exp2", fail_exp2, r.e);
        chk("fail_act2", fail_act2, r.x);
        chk("fail_cnt2_sat", fail_cnt2, r.cnt);
      end
    end
    done2_prev = done2;
  end

  task automatic push_one(input int code, input int a, input logic [DW-1:0] bg);
    op_exp_t o;
    o.we = (code >= 2);
    o.a  = a[AW-1:0];
    o.d  = code[0] ? ~bg : bg;
    opq.push_back(o);
  endtask

  // Op codes: 0=r0 1=r1 2=w0 3=w1, -1 = no second op; dir 1 = descending.
  task automatic push_ops(input logic alg, input logic [DW-1:0] bg);
    int dirs[6];
    int o0[6];
    int o1[6];
    int ne;
    if (alg) begin
      dirs = '{0, 0, 0, 1, 1, 0};
      o0   = '{2, 0, 1, 0, 1, 0};
      o1   = '{-1, 3, 2, 3, 2, -1};
      ne   = 6;
    end else begin
      dirs = '{0, 0, 1, 0, 0, 0};
      o0   = '{2, 0, 1, 0, 0, 0};
      o1   = '{-1, 3, 2, -1, -1, -1};
      ne   = 3;
    end
    for (int e = 0; e < ne; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = (dirs[e] != 0) ? (N - 1 - i) : i;
        push_one(o0[e], a, bg);
        if (o1[e] >= 0) push_one(o1[e], a, bg);
      end
    end
  endtask

  // Returns at the negedge of cycle 1 (start sampled at edge 0).
  task automatic run_start(input logic second, input logic alg, input logic sof,
                           input logic [DW-1:0] bg);
    @(negedge clk);
    alg_sel      = alg;
    stop_on_fail = sof;
    bg_pat       = bg;
    op_count     = 0;
    if (second) start2 = 1'b1;
    else        start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    t0     = cyc - 1;
  endtask

  task automatic wait_done(input logic second, input int budget);
    int n;
    n = 0;
    while (((second ? done2 : done) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(second ? "done2_seen" : "done_seen", second ? done2 : done, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    alg_sel = 1'b0; stop_on_fail = 1'b0; bg_pat = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_mem_ctrl", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
    chk("rst_fail_info", {fail_addr, fail_exp, fail_act}, 0);
    rst = 1'b0;

    // MATS+, fault-free, bg 0
    push_ops(1'b0, 4'h0);
    runq.push_back('{cyc:82, f:1'b0, a:4'h0, e:4'h0, x:4'h0, cnt:0, ops:80});
    run_start(1'b0, 1'b0, 1'b0, 4'h0);
    chk("busy_cycle1", busy, 1);
    wait_done(1'b0, 200);

    // March C-, fault-free, bg 0, full op/address sequence
    push_ops(1'b1, 4'h0);
    runq.push_back('{cyc:162, f:1'b0, a:4'h0, e:4'h0, x:4'h0, cnt:0, ops:160});
    run_start(1'b0, 1'b1, 1'b0, 4'h0);
    wait_done(1'b0, 300);

    // March C-, bg A, stuck-at-1 on bit 0 of address 5
    fault_en = 1'b1;
    runq.push_back('{cyc:162, f:1'b1, a:4'h5, e:4'hA, x:4'hB, cnt:3, ops:160});
    run_start(1'b0, 1'b1, 1'b0, 4'hA);
    wait_done(1'b0, 300);

    // Restart from DONE clears results; a start while busy is ignored
    fault_en = 1'b0;
    push_ops(1'b0, 4'h0);
    runq.push_back('{cyc:82, f:1'b0, a:4'h0, e:4'h0, x:4'h0, cnt:0, ops:80});
    run_start(1'b0, 1'b0, 1'b0, 4'h0);
    chk("restart_fail_cleared", fail, 0);
    chk("restart_cnt_cleared", fail_cnt, 0);
    chk("restart_info_cleared", {fail_addr, fail_exp, fail_act}, 0);
    repeat (29) @(negedge clk);
    alg_sel = 1'b1; bg_pat = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", busy, 1);
    wait_done(1'b0, 200);

    // Same fault with stop_on_fail: read at cycle 27, detect in 28, DONE from 29
    fault_en = 1'b1;
    we_after_done = 0;
    runq.push_back('{cyc:29, f:1'b1, a:4'h5, e:4'hA, x:4'hB, cnt:1, ops:28});
    run_start(1'b0, 1'b1, 1'b1, 4'hA);
    wait_done(1'b0, 300);
    repeat (5) @(negedge clk);
    chk("no_we_after_done", we_after_done, 0);
    chk("done_held", done, 1);

    // Reset in cycle 20 of a run
    fault_en = 1'b0;
    run_start(1'b0, 1'b1, 1'b0, 4'h0);
    repeat (19) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_done", {busy, done}, 0);
    chk("midrst_mem_ctrl", {mem_we, mem_re, mem_addr}, 0);
    chk("midrst_fail", {fail, fail_cnt}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {busy, done, mem_we, mem_re}, 0);

    // FCW=2 instance, every read mismatches: count saturates at 3
    runq2.push_back('{cyc:82, f:1'b1, a:4'h0, e:4'h3, x:4'hC, cnt:3, ops:0});
    run_start(1'b1, 1'b0, 1'b0, 4'h3);
    wait_done(1'b1, 200);

    chk("run_queue_drained", runq.size() + runq2.size(), 0);
    chk("op_queue_drained", opq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
